mem_stage: RTL and testbench

MEM_STAGE -- requirements
Module: mem_stage

---
 rtl/pipeline_pkg.sv | 24 ++
 rtl/RegM.sv | 53 +++++
 rtl/mem_stage.sv | 137 +++++++++++++
 tb/tb_mem_stage.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/pipeline_pkg.sv
`default_nettype none
// ============================================================================
// Module   : pipeline_pkg
// Purpose  : Shared memory-stage types, defaults and the counter width helper.
// Revision : 1.0  initial release
// ============================================================================
package pipeline_pkg;

   localparam int DMEM_TIMEOUT_DEFAULT = 255;

   typedef enum logic [0:0] {
      IDLE = 1'b0,
      WAIT = 1'b1
   } mem_state_t;

   // Wait counter is at least 8 bits and always wide enough to reach the timeout.
   function automatic int cnt_width(input int timeout);
      int w;
      w = $clog2(timeout + 1);
      return (w < 8) ? 8 : w;
   endfunction

endpackage
`default_nettype wire

// File: rtl/RegM.sv
`default_nettype none
// ============================================================================
// Module   : RegM
// Purpose  : M/W pipeline register with bubble insertion and async reset.
// Revision : 1.0  initial release
// ============================================================================
module RegM (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        bubble,
   input  logic        reg_write_m,
   input  logic        result_src_m,
   input  logic [31:0] alu_result_m,
   input  logic [4:0]  rd_m,
   input  logic        load_done,
   input  logic [31:0] load_data,
   input  logic        mem_err,
   output logic        RegWriteW,
   output logic        ResultSrcW,
   output logic [31:0] ALUResultW,
   output logic [31:0] ReadDataW,
   output logic [4:0]  RdW,
   output logic        MemErrW
);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         RegWriteW  <= 1'b0;
         ResultSrcW <= 1'b0;
         ALUResultW <= 32'd0;
         ReadDataW  <= 32'd0;
         RdW        <= 5'd0;
         MemErrW    <= 1'b0;
      end else begin
         MemErrW <= mem_err;
         if (load_done) begin
            ReadDataW <= load_data;
         end
         // A bubble kills the control bits but leaves the data fields untouched.
         if (bubble) begin
            RegWriteW  <= 1'b0;
            ResultSrcW <= 1'b0;
         end else begin
            RegWriteW  <= reg_write_m;
            ResultSrcW <= result_src_m;
            ALUResultW <= alu_result_m;
            RdW        <= rd_m;
         end
      end
   end

endmodule
`default_nettype wire

// File: rtl/mem_stage.sv
`default_nettype none
// ============================================================================
// Module   : mem_stage
// Purpose  : Pipeline memory stage: dmem handshake FSM, timeout, M/W register.
// Revision : 1.0  initial release
// ============================================================================
module mem_stage
   import pipeline_pkg::*;
#(
   parameter int TIMEOUT = DMEM_TIMEOUT_DEFAULT
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        ValidM,
   input  logic        RegWriteM,
   input  logic        ResultSrcM,
   input  logic        MemWriteM,
   input  logic [31:0] ALUResultM,
   input  logic [31:0] WriteDataM,
   input  logic [4:0]  RdM,
   output logic        dmem_req,
   output logic        dmem_we,
   output logic [31:0] dmem_addr,
   output logic [31:0] dmem_wdata,
   input  logic        dmem_ready,
   input  logic [31:0] dmem_rdata,
   output logic        StallM,
   output logic        RegWriteW,
   output logic        ResultSrcW,
   output logic [31:0] ALUResultW,
   output logic [31:0] ReadDataW,
   output logic [4:0]  RdW,
   output logic        MemErrW
);

   localparam int               CNT_W     = cnt_width(TIMEOUT);
   localparam logic [CNT_W-1:0] c_TIMEOUT = CNT_W'(TIMEOUT);
   localparam logic [CNT_W-1:0] c_ONE     = CNT_W'(1);

   mem_state_t       r_state;
   mem_state_t       w_state_nx;
   logic [CNT_W-1:0] r_cnt;
   logic [CNT_W-1:0] w_cnt_nx;

   logic w_mem_op;
   logic w_misaligned;
   logic w_req;
   logic w_stall;
   logic w_abandon;
   logic w_load_done;
   logic w_reg_write;

   assign w_mem_op     = ValidM & (ResultSrcM | MemWriteM);
   assign w_misaligned = w_mem_op & (ALUResultM[1:0] != 2'b00);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= IDLE;
         r_cnt   <= '0;
      end else begin
         r_state <= w_state_nx;
         r_cnt   <= w_cnt_nx;
      end
   end

   always_comb begin
      w_state_nx = r_state;
      w_cnt_nx   = r_cnt;
      w_req      = 1'b0;
      w_stall    = 1'b0;
      w_abandon  = 1'b0;
      case (r_state)
         IDLE: begin
            if (w_misaligned) begin
               w_abandon = 1'b1;
            end else if (w_mem_op) begin
               w_req = 1'b1;
               if (!dmem_ready) begin
                  w_state_nx = WAIT;
                  w_cnt_nx   = c_ONE;
                  w_stall    = 1'b1;
               end
            end
         end
         WAIT: begin
            w_req = 1'b1;
            if (dmem_ready) begin
               w_state_nx = IDLE;
               w_cnt_nx   = '0;
            end else if (r_cnt >= c_TIMEOUT) begin
               // Give up: release the pipeline and flag the error next cycle.
               w_state_nx = IDLE;
               w_cnt_nx   = '0;
               w_abandon  = 1'b1;
            end else begin
               w_cnt_nx = r_cnt + c_ONE;
               w_stall  = 1'b1;
            end
         end
         default: begin
            w_state_nx = IDLE;
            w_cnt_nx   = '0;
         end
      endcase
   end

   // Gating with rst_n drops the request and stall as soon as reset asserts.
   assign dmem_req    = w_req & rst_n;
   assign StallM      = w_stall & rst_n;
   assign dmem_we     = MemWriteM;
   assign dmem_addr   = ALUResultM;
   assign dmem_wdata  = WriteDataM;

   assign w_load_done = w_req & dmem_ready & ResultSrcM;
   assign w_reg_write = RegWriteM & ValidM & ~w_abandon;

   RegM u_regm (
      .clk          (clk),
      .rst_n        (rst_n),
      .bubble       (w_stall),
      .reg_write_m  (w_reg_write),
      .result_src_m (ResultSrcM),
      .alu_result_m (ALUResultM),
      .rd_m         (RdM),
      .load_done    (w_load_done),
      .load_data    (dmem_rdata),
      .mem_err      (w_abandon),
      .RegWriteW    (RegWriteW),
      .ResultSrcW   (ResultSrcW),
      .ALUResultW   (ALUResultW),
      .ReadDataW    (ReadDataW),
      .RdW          (RdW),
      .MemErrW      (MemErrW)
   );

endmodule
`default_nettype wire

// File: tb/tb_mem_stage.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem_stage
// Purpose  : Directed scoreboard bench for mem_stage (short timeout instance).
// Revision : 1.0  initial release
// ============================================================================
module tb_mem_stage;

   logic        clk;
   logic        rst_n;
   logic        ValidM, RegWriteM, ResultSrcM, MemWriteM;
   logic [31:0] ALUResultM, WriteDataM;
   logic [4:0]  RdM;
   logic        dmem_req, dmem_we, dmem_ready;
   logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;
   logic        StallM;
   logic        RegWriteW, ResultSrcW, MemErrW;
   logic [31:0] ALUResultW, ReadDataW;
   logic [4:0]  RdW;

   int n_vec = 0;
   int n_bad = 0;

   typedef struct {
      string       nm;
      logic        req;
      logic        we;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic        stall;
      logic        rw;
      logic        rs;
      logic        err;
      logic [31:0] alu;
      logic [4:0]  rd;
      logic [31:0] rdata;
   } exp_t;

   exp_t q[$];
   exp_t e;

   mem_stage #(.TIMEOUT(4)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .ValidM     (ValidM),
      .RegWriteM  (RegWriteM),
      .ResultSrcM (ResultSrcM),
      .MemWriteM  (MemWriteM),
      .ALUResultM (ALUResultM),
      .WriteDataM (WriteDataM),
      .RdM        (RdM),
      .dmem_req   (dmem_req),
      .dmem_we    (dmem_we),
      .dmem_addr  (dmem_addr),
      .dmem_wdata (dmem_wdata),
      .dmem_ready (dmem_ready),
      .dmem_rdata (dmem_rdata),
      .StallM     (StallM),
      .RegWriteW  (RegWriteW),
      .ResultSrcW (ResultSrcW),
      .ALUResultW (ALUResultW),
      .ReadDataW  (ReadDataW),
      .RdW        (RdW),
      .MemErrW    (MemErrW)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   // Monitor: every queued expectation is checked at the falling edge.
   always @(negedge clk) begin
      if (q.size() != 0) begin
         e = q.pop_front();
         chk({e.nm, " dmem_req"}, 32'(dmem_req), 32'(e.req));
         chk({e.nm, " StallM"},   32'(StallM),   32'(e.stall));
         if (e.req) begin
            chk({e.nm, " dmem_we"},    32'(dmem_we), 32'(e.we));
            chk({e.nm, " dmem_addr"},  dmem_addr,    e.addr);
            chk({e.nm, " dmem_wdata"}, dmem_wdata,   e.wdata);
         end
         chk({e.nm, " RegWriteW"},  32'(RegWriteW),  32'(e.rw));
         chk({e.nm, " ResultSrcW"}, 32'(ResultSrcW), 32'(e.rs));
         chk({e.nm, " MemErrW"},    32'(MemErrW),    32'(e.err));
         chk({e.nm, " ALUResultW"}, ALUResultW,      e.alu);
         chk({e.nm, " RdW"},        32'(RdW),        32'(e.rd));
         chk({e.nm, " ReadDataW"},  ReadDataW,       e.rdata);
      end
   end

   task automatic drv(input logic v, input logic rw, input logic rs, input logic mw,
                      input logic [31:0] a, input logic [31:0] wd, input logic [4:0] rd,
                      input logic rdy, input logic [31:0] rdat);
      @(posedge clk);
      #1;
      ValidM = v; RegWriteM = rw; ResultSrcM = rs; MemWriteM = mw;
      ALUResultM = a; WriteDataM = wd; RdM = rd;
      dmem_ready = rdy; dmem_rdata = rdat;
   endtask

   task automatic bub(input logic [31:0] a, input logic [4:0] rd,
                      input logic rdy, input logic [31:0] rdat);
      drv(1'b0, 1'b0, 1'b0, 1'b0, a, 32'd0, rd, rdy, rdat);
   endtask

   task automatic expect_cyc(input string nm, input logic req, input logic we,
                             input logic [31:0] addr, input logic [31:0] wdata,
                             input logic stall, input logic rw, input logic rs,
                             input logic err, input logic [31:0] alu,
                             input logic [4:0] rd, input logic [31:0] rdata);
      exp_t x;
      x.nm = nm; x.req = req; x.we = we; x.addr = addr; x.wdata = wdata;
      x.stall = stall; x.rw = rw; x.rs = rs; x.err = err;
      x.alu = alu; x.rd = rd; x.rdata = rdata;
      q.push_back(x);
   endtask

   task automatic chk_reset_now(input string nm);
      chk({nm, " dmem_req"},   32'(dmem_req),   32'd0);
      chk({nm, " StallM"},     32'(StallM),     32'd0);
      chk({nm, " RegWriteW"},  32'(RegWriteW),  32'd0);
      chk({nm, " ResultSrcW"}, 32'(ResultSrcW), 32'd0);
      chk({nm, " ALUResultW"}, ALUResultW,      32'd0);
      chk({nm, " ReadDataW"},  ReadDataW,       32'd0);
      chk({nm, " RdW"},        32'(RdW),        32'd0);
      chk({nm, " MemErrW"},    32'(MemErrW),    32'd0);
   endtask

   initial begin
      rst_n = 1'b1;
      ValidM = 0; RegWriteM = 0; ResultSrcM = 0; MemWriteM = 0;
      ALUResultM = 0; WriteDataM = 0; RdM = 0; dmem_ready = 0; dmem_rdata = 0;
      #1 rst_n = 1'b0;
      #2 chk_reset_now("reset");
      @(negedge clk) rst_n = 1'b1;

      // ALU op, then a bubble carrying a stray ready that must be ignored
      drv(1, 1, 0, 0, 32'h2A, 32'd0, 5'd5, 0, 32'd0);
      expect_cyc("alu0", 0, 0, 0, 0, 0, 0, 0, 0, 32'h0, 5'd0, 32'h0);
      bub(32'h0, 5'd0, 1, 32'hFFFF_FFFF);
      expect_cyc("alu1", 0, 0, 0, 0, 0, 1, 0, 0, 32'h2A, 5'd5, 32'h0);

      // Load 0x100, ready arrives on the fourth cycle
      drv(1, 1, 1, 0, 32'h100, 32'd0, 5'd7, 0, 32'd0);
      expect_cyc("ld0", 1, 0, 32'h100, 32'd0, 1, 0, 0, 0, 32'h0, 5'd0, 32'h0);
      drv(1, 1, 1, 0, 32'h100, 32'd0, 5'd7, 0, 32'd0);
      expect_cyc("ld1", 1, 0, 32'h100, 32'd0, 1, 0, 0, 0, 32'h0, 5'd0, 32'h0);
      drv(1, 1, 1, 0, 32'h100, 32'd0, 5'd7, 0, 32'd0);
      expect_cyc("ld2", 1, 0, 32'h100, 32'd0, 1, 0, 0, 0, 32'h0, 5'd0, 32'h0);
      drv(1, 1, 1, 0, 32'h100, 32'd0, 5'd7, 1, 32'hCAFE_F00D);
      expect_cyc("ld3", 1, 0, 32'h100, 32'd0, 0, 0, 0, 0, 32'h0, 5'd0, 32'h0);
      bub(32'h0, 5'd0, 0, 32'd0);
      expect_cyc("ld4", 0, 0, 0, 0, 0, 1, 1, 0, 32'h100, 5'd7, 32'hCAFE_F00D);

      // Single-cycle store
      drv(1, 0, 0, 1, 32'h204, 32'hDEAD_BEEF, 5'd6, 1, 32'h1111_1111);
      expect_cyc("st0", 1, 1, 32'h204, 32'hDEAD_BEEF, 0, 0, 0, 0, 32'h0, 5'd0, 32'hCAFE_F00D);
      bub(32'h0, 5'd0, 0, 32'd0);
      expect_cyc("st1", 0, 0, 0, 0, 0, 0, 0, 0, 32'h204, 5'd6, 32'hCAFE_F00D);

      // Misaligned load: no request, ready ignored, one error pulse
      drv(1, 1, 1, 0, 32'h102, 32'd0, 5'd9, 1, 32'h0BAD_F00D);
      expect_cyc("mis0", 0, 0, 0, 0, 0, 0, 0, 0, 32'h0, 5'd0, 32'hCAFE_F00D);
      bub(32'h0, 5'd0, 0, 32'd0);
      expect_cyc("mis1", 0, 0, 0, 0, 0, 0, 1, 1, 32'h102, 5'd9, 32'hCAFE_F00D);
      bub(32'h0, 5'd0, 0, 32'd0);
      expect_cyc("mis2", 0, 0, 0, 0, 0, 0, 0, 0, 32'h0, 5'd0, 32'hCAFE_F00D);

      // Timeout of 4: request cycles are IDLE plus CNT=1..4, the last one releases
      for (int i = 0; i < 5; i++) begin
         drv(1, 1, 1, 0, 32'h300, 32'd0, 5'd3, 0, 32'd0);
         expect_cyc($sformatf("to%0d", i), 1, 0, 32'h300, 32'd0, (i < 4) ? 1'b1 : 1'b0,
                    0, 0, 0, 32'h0, 5'd0, 32'hCAFE_F00D);
      end
      bub(32'h55, 5'd2, 0, 32'd0);
      expect_cyc("to5", 0, 0, 0, 0, 0, 0, 1, 1, 32'h300, 5'd3, 32'hCAFE_F00D);
      bub(32'h55, 5'd2, 0, 32'd0);
      expect_cyc("to6", 0, 0, 0, 0, 0, 0, 0, 0, 32'h55, 5'd2, 32'hCAFE_F00D);

      // Reset in the middle of a wait, then the held load completes at once
      drv(1, 1, 1, 0, 32'h400, 32'd0, 5'd4, 0, 32'd0);
      expect_cyc("rw0", 1, 0, 32'h400, 32'd0, 1, 0, 0, 0, 32'h55, 5'd2, 32'hCAFE_F00D);
      drv(1, 1, 1, 0, 32'h400, 32'd0, 5'd4, 0, 32'd0);
      expect_cyc("rw1", 1, 0, 32'h400, 32'd0, 1, 0, 0, 0, 32'h55, 5'd2, 32'hCAFE_F00D);
      #6 rst_n = 1'b0;
      #1 chk_reset_now("midwait_reset");
      @(negedge clk);
      dmem_ready = 1'b1;
      dmem_rdata = 32'h1234_5678;
      rst_n      = 1'b1;
      #1;
      chk("post_reset dmem_req", 32'(dmem_req), 32'd1);
      chk("post_reset StallM",   32'(StallM),   32'd0);
      bub(32'h0, 5'd0, 0, 32'd0);
      expect_cyc("rw2", 0, 0, 0, 0, 0, 1, 1, 0, 32'h400, 5'd4, 32'h1234_5678);
      bub(32'h0, 5'd0, 0, 32'd0);
      expect_cyc("rw3", 0, 0, 0, 0, 0, 0, 0, 0, 32'h0, 5'd0, 32'h1234_5678);

      for (int i = 0; i < 20 && q.size() != 0; i++) @(negedge clk);
      if (q.size() != 0) begin
         n_vec++;
         n_bad++;
         $display("FAIL drain: got %0d pending expected 0", q.size());
      end
      @(posedge clk);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
`default_nettype wire
